// File: rtl/hi_low_solver_pkg.sv
// ----------------------------------------------------------------------------
// hi_low_solver_pkg
//  Constants shared by the hi/low solver and the game core's hint encoder:
//  the 2-bit hint codes and the solver FSM state encoding.
// ----------------------------------------------------------------------------
package hi_low_solver_pkg;

    // Hint codes, as produced by the game core for the current guess
    localparam logic [1:0] HINT_EQ  = 2'b00;  // guess == target
    localparam logic [1:0] HINT_LO  = 2'b01;  // guess <  target
    localparam logic [1:0] HINT_HI  = 2'b10;  // guess >  target
    localparam logic [1:0] HINT_RSV = 2'b11;  // reserved, treated as a fault

    // Solver FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CALC    = 3'd1,
        ST_PROPOSE = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

endpackage : hi_low_solver_pkg

// File: rtl/hi_low_solver.sv
// ----------------------------------------------------------------------------
// hi_low_solver
//  Automatic player for the hi/low guessing game. Binary search over
//  [0, 2^WIDTH-1]: propose a midpoint, take back a hint, narrow the bounds.
//
//  Ports
//   clk          in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   start        in   1-cycle pulse, begins a search from IDLE/DONE/ERROR
//   hint_valid   in   hint is presented for the current guess
//   hint         in   HINT_EQ / HINT_LO / HINT_HI / HINT_RSV
//   guess        out  current proposed guess (holds the answer when done)
//   guess_valid  out  guess is stable and awaits a hint (PROPOSE only)
//   guess_count  out  guesses issued in this search, saturating
//   done         out  search ended with EQUAL
//   error        out  inconsistent or reserved hint, search aborted
// ----------------------------------------------------------------------------
module hi_low_solver
    import hi_low_solver_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             hint_valid,
    input  logic [1:0]       hint,
    output logic [WIDTH-1:0] guess,
    output logic             guess_valid,
    output logic [CNT_W-1:0] guess_count,
    output logic             done,
    output logic             error
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_guess;
    logic             r_guess_valid;
    logic [CNT_W-1:0] r_count;
    logic             r_done;
    logic             r_error;

    logic [WIDTH-1:0] w_mid;
    logic [WIDTH-1:0] w_lo_next;
    logic [WIDTH-1:0] w_hi_next;
    logic             w_lo_cross;
    logic             w_hi_cross;
    logic             w_hint_valid;
    logic [1:0]       w_hint;

    // Midpoint and candidate bounds for the hint currently being judged
    always_comb begin
        // Sum taken one bit wider so lo+hi never wraps before halving
        w_mid        = WIDTH'(({1'b0, r_lo} + {1'b0, r_hi}) >> 1'b1);
        w_lo_next    = r_guess + ONE_W;
        w_hi_next    = r_guess - ONE_W;
        w_lo_cross   = (w_lo_next > r_hi);
        w_hi_cross   = (r_lo > w_hi_next);
        w_hint_valid = hint_valid;
        w_hint       = hint;
    end

    // Solver FSM: bounds, guess, count and status flags are all registered here
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_lo          <= ZERO_W;
            r_hi          <= MAX_VAL;
            r_guess       <= ZERO_W;
            r_guess_valid <= 1'b0;
            r_count       <= {CNT_W{1'b0}};
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    // Terminal/idle states hold every output until start
                    if (start) begin
                        r_lo          <= ZERO_W;
                        r_hi          <= MAX_VAL;
                        r_count       <= {CNT_W{1'b0}};
                        r_done        <= 1'b0;
                        r_error       <= 1'b0;
                        r_guess_valid <= 1'b0;
                        r_state       <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_guess       <= w_mid;
                    if (r_count != CNT_MAX) begin
                        r_count <= r_count + CNT_ONE;
                    end
                    r_guess_valid <= 1'b1;
                    r_state       <= ST_PROPOSE;
                end
                ST_PROPOSE: begin
                    if (w_hint_valid) begin
                        r_guess_valid <= 1'b0;
                        case (w_hint)
                            HINT_EQ: begin
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end
                            HINT_LO: begin
                                // Target above the maximum, or bounds crossed: oracle lied
                                if ((r_guess == MAX_VAL) || w_lo_cross) begin
                                    r_error <= 1'b1;
                                    r_state <= ST_ERROR;
                                end else begin
                                    r_lo    <= w_lo_next;
                                    r_state <= ST_CALC;
                                end
                            end
                            HINT_HI: begin
                                if ((r_guess == ZERO_W) || w_hi_cross) begin
                                    r_error <= 1'b1;
                                    r_state <= ST_ERROR;
                                end else begin
                                    r_hi    <= w_hi_next;
                                    r_state <= ST_CALC;
                                end
                            end
                            default: begin
                                r_error <= 1'b1;
                                r_state <= ST_ERROR;
                            end
                        endcase
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle
                    r_guess_valid <= 1'b0;
                    r_done        <= 1'b0;
                    r_error       <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign guess       = r_guess;
    assign guess_valid = r_guess_valid;
    assign guess_count = r_count;
    assign done        = r_done;
    assign error       = r_error;

endmodule : hi_low_solver

// File: tb/tb_hi_low_solver.sv
// ----------------------------------------------------------------------------
// tb_hi_low_solver
//  Scoreboard bench for hi_low_solver (WIDTH=4). A reference binary search on
//  plain integers queues the expected guess sequence and final outcome; a
//  monitor pops and compares whenever guess_valid, done or error rises.
// ----------------------------------------------------------------------------
module tb_hi_low_solver;
    import hi_low_solver_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk;
    logic             resetn;
    logic             start;
    logic             hint_valid;
    logic [1:0]       hint;
    logic [WIDTH-1:0] guess;
    logic             guess_valid;
    logic [CNT_W-1:0] guess_count;
    logic             done;
    logic             error;

    hi_low_solver #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk,
        .resetn,
        .start,
        .hint_valid,
        .hint,
        .guess,
        .guess_valid,
        .guess_count,
        .done,
        .error
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = new guess proposed, 1 = done, 2 = error
    typedef struct {
        int kind;
        int g;
        int cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] script [8];
    int         nchecks = 0;
    int         nerrors = 0;

    task automatic check(input string name, input int act, input int expv);
        nchecks++;
        if (act != expv) begin
            nerrors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Oracle: mode 0 answers truthfully for target, mode 1 replays script
    function automatic logic [1:0] oracle(input int mode, input int target, input int g, input int idx);
        if (mode == 0) begin
            if (g == target) return HINT_EQ;
            else if (g < target) return HINT_LO;
            else return HINT_HI;
        end else begin
            return script[idx % 8];
        end
    endfunction

    // Reference search: integer bounds, queue every expected event
    task automatic model_push(input int mode, input int target);
        int lo = 0;
        int hi = MAXV;
        int n = 0;
        int g;
        logic [1:0] h;
        bit fin = 0;
        while (!fin && n < 10) begin
            g = (lo + hi) / 2;
            n++;
            exp_q.push_back('{0, g, n});
            h = oracle(mode, target, g, n - 1);
            if (h == HINT_EQ) begin
                exp_q.push_back('{1, g, n});
                fin = 1;
            end else if (h == HINT_LO) begin
                lo = g + 1;
                if (g == MAXV || lo > hi) begin
                    exp_q.push_back('{2, g, n});
                    fin = 1;
                end
            end else if (h == HINT_HI) begin
                hi = g - 1;
                if (g == 0 || lo > hi) begin
                    exp_q.push_back('{2, g, n});
                    fin = 1;
                end
            end else begin
                exp_q.push_back('{2, g, n});
                fin = 1;
            end
        end
    endtask

    task automatic pop_and_check(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL unexpected_event: got kind %0d guess %0d count %0d, expected no event",
                     kind, guess, guess_count);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("guess", int'(guess), e.g);
            check("guess_count", int'(guess_count), e.cnt);
            if (kind != 0) begin
                check("gv_low_at_end", int'(guess_valid), 0);
                check("done_error_exclusive", int'(done && error), 0);
            end
        end
    endtask

    // Monitor: compares on every rising guess_valid / done / error
    initial begin
        bit pv = 0, pd = 0, pe = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pv = 0; pd = 0; pe = 0;
            end else begin
                if (guess_valid && !pv) pop_and_check(0);
                if (done && !pd) pop_and_check(1);
                if (error && !pe) pop_and_check(2);
                pv = guess_valid; pd = done; pe = error;
            end
        end
    end

    task automatic run_search(input int mode, input int target, input bit inj);
        int idx = 0;
        int w;
        int d;
        bit fin = 0;
        logic [1:0] h;
        model_push(mode, target);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        // Now in CALC: status cleared, nothing proposed yet
        check("calc_done", int'(done), 0);
        check("calc_error", int'(error), 0);
        check("calc_count", int'(guess_count), 0);
        check("calc_gv", int'(guess_valid), 0);
        while (!fin && idx < 10) begin
            w = 0;
            while (!guess_valid && w < 10) begin
                @(posedge clk); #1;
                w++;
            end
            if (!guess_valid) begin
                check("guess_valid_timeout", 0, 1);
                fin = 1;
            end else begin
                d = $urandom_range(0, 2);
                if (inj && idx == 1) begin
                    start = 1'b1;
                    @(posedge clk); #1 start = 1'b0;
                end
                repeat (d) begin
                    @(posedge clk); #1;
                end
                h = oracle(mode, target, int'(guess), idx);
                hint_valid = 1'b1;
                hint = h;
                @(posedge clk); #1;
                hint_valid = 1'b0;
                hint = 2'($urandom_range(0, 3));
                idx++;
                if (done || error) fin = 1;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        hint_valid = 1'b0;
        hint = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_guess", int'(guess), 0);
        check("rst_gv", int'(guess_valid), 0);
        check("rst_count", int'(guess_count), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        resetn = 1'b1;

        // Stray hint in IDLE must do nothing
        @(posedge clk); #1 hint_valid = 1'b1; hint = HINT_LO;
        repeat (2) @(posedge clk);
        #1 hint_valid = 1'b0;
        check("idle_stray_gv", int'(guess_valid), 0);
        check("idle_stray_count", int'(guess_count), 0);

        // Directed searches
        run_search(0, 4, 0);
        // Stray hint while DONE must not disturb the held result
        hint_valid = 1'b1; hint = HINT_HI;
        repeat (2) @(posedge clk);
        #1 hint_valid = 1'b0;
        check("done_hold_done", int'(done), 1);
        check("done_hold_guess", int'(guess), 4);
        check("done_hold_count", int'(guess_count), 4);
        check("done_hold_gv", int'(guess_valid), 0);

        run_search(0, 14, 0);
        run_search(0, 15, 0);
        run_search(0, 0, 0);
        for (int i = 0; i < 8; i++) script[i] = HINT_HI;
        run_search(1, 0, 0);
        for (int i = 0; i < 8; i++) script[i] = HINT_LO;
        run_search(1, 0, 0);
        script[0] = HINT_RSV;
        run_search(1, 0, 0);
        run_search(0, 9, 1);

        // Async reset while a guess is awaiting its hint
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        exp_q.push_back('{0, 7, 1});
        begin
            int w = 0;
            while (!guess_valid && w < 10) begin
                @(posedge clk); #1;
                w++;
            end
        end
        check("pre_reset_gv", int'(guess_valid), 1);
        #1 resetn = 1'b0;
        #1;
        check("async_rst_guess", int'(guess), 0);
        check("async_rst_gv", int'(guess_valid), 0);
        check("async_rst_count", int'(guess_count), 0);
        check("async_rst_done", int'(done), 0);
        check("async_rst_error", int'(error), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Randomized searches: truthful targets and scripted (possibly lying) oracles
        for (int n = 0; n < 30; n++) begin
            int mode;
            mode = $urandom_range(0, 1);
            for (int i = 0; i < 8; i++) script[i] = 2'($urandom_range(0, 3));
            run_search(mode, $urandom_range(0, MAXV), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule : tb_hi_low_solver
